// File: rtl/lmsm_pkg.sv
// Shared constants and state type for the LM/SM micro-op sequencer.
// The optional WB state is only used when LMSM_BASE_WB_EN is defined.
package lmsm_pkg;
  localparam int XLEN   = 16;
  localparam int LIST_W = 8;
  localparam int RA_W   = 3;
  localparam int CNT_W  = $clog2(LIST_W + 1);

  localparam logic [3:0] OPC_LM = 4'b0110;
  localparam logic [3:0] OPC_SM = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEQ  = 2'd1,
    WB   = 2'd2
  } state_e;
endpackage

// File: rtl/lmsm_sequencer_lsb_priority_encoder.sv
// Lowest-set-bit priority encoder over the remaining register list.
// Gives the bit index, its one-hot mask and an exactly-one-bit flag.
module lsb_priority_encoder
  import lmsm_pkg::*;
(
  input  logic [LIST_W-1:0] mask_i,
  output logic [RA_W-1:0]   idx_o,
  output logic [LIST_W-1:0] onehot_o,
  output logic              exactly_one_o
);

  assign onehot_o      = mask_i & (~mask_i + LIST_W'(1));
  assign exactly_one_o = (mask_i != '0) && ((mask_i & (mask_i - LIST_W'(1))) == '0);

  // Scan from the top so the lowest set bit is the final write.
  always_comb begin
    idx_o = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = RA_W'(i);
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: parks the instruction in IF/ID and emits one load/store
// micro-op per cycle. LMSM_BASE_WB_EN adds a trailing base-writeback micro-op.
//
// state | meaning
// IDLE  | watching IF/ID for a non-empty LM/SM
// SEQ   | issuing one transfer per unheld cycle, lowest register first
// WB    | base writeback micro-op RA <- RA + N (LMSM_BASE_WB_EN only)
module lmsm_sequencer
  import lmsm_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            ir_valid,
  input  logic [XLEN-1:0] ir_in,
  input  logic            hold,
  input  logic            flush,
  output logic            stall_fetch,
  output logic            kill_decode,
  output logic            busy,
  output logic            uop_valid,
  output logic            uop_load,
  output logic            uop_store,
  output logic [RA_W-1:0] uop_reg,
  output logic [RA_W-1:0] uop_base,
  output logic [XLEN-1:0] uop_offset,
  output logic            uop_last
);

  state_e              state_q, state_d;
  logic [LIST_W-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [RA_W-1:0]     base_q, base_d;
  logic                load_q, load_d;

  logic [RA_W-1:0]     enc_idx;
  logic [LIST_W-1:0]   enc_onehot;
  logic                enc_one;
  logic                is_lmsm, start;
  logic [XLEN-1:0]     offset_ext;

  lsb_priority_encoder u_enc (
    .mask_i        (mask_q),
    .idx_o         (enc_idx),
    .onehot_o      (enc_onehot),
    .exactly_one_o (enc_one)
  );

  assign is_lmsm    = (ir_in[15:12] == OPC_LM) || (ir_in[15:12] == OPC_SM);
  assign start      = (state_q == IDLE) && ir_valid && is_lmsm &&
                      (ir_in[LIST_W-1:0] != '0) && !flush;
  assign offset_ext = {{(XLEN-CNT_W){1'b0}}, count_q};
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    count_d     = count_q;
    base_d      = base_q;
    load_d      = load_q;
    stall_fetch = 1'b0;
    kill_decode = 1'b0;
    uop_valid   = 1'b0;
    uop_load    = 1'b0;
    uop_store   = 1'b0;
    uop_reg     = '0;
    uop_base    = '0;
    uop_offset  = '0;
    uop_last    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          stall_fetch = 1'b1;
          kill_decode = 1'b1;
          if (!hold) begin
            mask_d  = ir_in[LIST_W-1:0];
            base_d  = ir_in[11:9];
            load_d  = (ir_in[15:12] == OPC_LM);
            count_d = '0;
            state_d = SEQ;
          end
        end else if (ir_valid && is_lmsm && (ir_in[LIST_W-1:0] == '0)) begin
          // Empty list retires as a NOP without stalling fetch.
          kill_decode = 1'b1;
        end
      end

      SEQ: begin
        uop_valid  = 1'b1;
        uop_load   = load_q;
        uop_store  = !load_q;
        uop_reg    = enc_idx;
        uop_base   = base_q;
        uop_offset = offset_ext;
`ifdef LMSM_BASE_WB_EN
        stall_fetch = 1'b1;
        kill_decode = 1'b1;
        if (!hold) begin
          mask_d  = mask_q & ~enc_onehot;
          count_d = count_q + CNT_W'(1);
          if (enc_one) state_d = WB;
        end
`else
        uop_last    = enc_one;
        stall_fetch = !(enc_one && !hold);
        kill_decode = !(enc_one && !hold);
        if (!hold) begin
          mask_d  = mask_q & ~enc_onehot;
          count_d = count_q + CNT_W'(1);
          if (enc_one) state_d = IDLE;
        end
`endif
      end

`ifdef LMSM_BASE_WB_EN
      WB: begin
        uop_valid   = 1'b1;
        uop_reg     = base_q;
        uop_base    = base_q;
        uop_offset  = offset_ext;
        uop_last    = 1'b1;
        stall_fetch = hold;
        kill_decode = hold;
        if (!hold) state_d = IDLE;
      end
`endif

      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      mask_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      count_q <= '0;
      base_q  <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      base_q  <= base_d;
      load_q  <= load_d;
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Self-checking bench for lmsm_sequencer: a queue-based model checked every
// cycle plus literal micro-op logs and stall counts for each directed case.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        reset, ir_valid, hold, flush;
  logic [15:0] ir_in;
  logic        stall_fetch, kill_decode, busy, uop_valid, uop_load, uop_store, uop_last;
  logic [2:0]  uop_reg, uop_base;
  logic [15:0] uop_offset;

  always #5 clk = ~clk;

  lmsm_sequencer dut (
    .clk(clk), .reset(reset), .ir_valid(ir_valid), .ir_in(ir_in),
    .hold(hold), .flush(flush),
    .stall_fetch(stall_fetch), .kill_decode(kill_decode), .busy(busy),
    .uop_valid(uop_valid), .uop_load(uop_load), .uop_store(uop_store),
    .uop_reg(uop_reg), .uop_base(uop_base), .uop_offset(uop_offset),
    .uop_last(uop_last)
  );

  logic [28:0] dut_vec;
  assign dut_vec = {stall_fetch, kill_decode, busy, uop_valid, uop_load, uop_store,
                    uop_reg, uop_base, uop_offset, uop_last};

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int enc(input int l, input int s, input int r, input int o);
    return l * 4096 + s * 2048 + r * 256 + o;
  endfunction

  // Model: remaining registers kept as an ordered queue of indices.
  bit m_on = 0;
  bit m_busy = 0;
  int m_q[$];
  int m_base = 0, m_off = 0;
  bit m_load = 0;

  int log_q[$];
  int stall_cnt = 0, kill_cnt = 0, last_cnt = 0;

  always @(negedge clk) begin
    bit e_st, e_k, e_v, e_l, e_s, e_last, lmsm;
    int e_reg, e_base, e_off;
    logic [7:0] lst;
    logic [28:0] exp_vec;
    e_st = 0; e_k = 0; e_v = 0; e_l = 0; e_s = 0; e_last = 0;
    e_reg = 0; e_base = 0; e_off = 0;
    lst  = ir_in[7:0];
    lmsm = ir_valid && (ir_in[15:12] == 4'd6 || ir_in[15:12] == 4'd7);

    if (!m_busy) begin
      if (lmsm && lst != 0 && !flush) begin e_st = 1; e_k = 1; end
      else if (lmsm && lst == 0) e_k = 1;
    end else if (m_q.size() > 0) begin
      e_v = 1; e_l = m_load; e_s = !m_load;
      e_reg = m_q[0]; e_base = m_base; e_off = m_off;
`ifdef LMSM_BASE_WB_EN
      e_last = 0; e_st = 1;
`else
      e_last = (m_q.size() == 1);
      e_st = !(e_last && !hold);
`endif
      e_k = e_st;
    end else begin
      e_v = 1; e_reg = m_base; e_base = m_base; e_off = m_off;
      e_last = 1; e_st = hold; e_k = hold;
    end

    if (m_on) begin
      exp_vec = {e_st, e_k, m_busy, e_v, e_l, e_s, 3'(e_reg), 3'(e_base), 16'(e_off), e_last};
      chk("cycle_outputs", int'(dut_vec), int'(exp_vec));
    end

    if (!reset) begin
      if (uop_valid && !hold && !flush)
        log_q.push_back(enc(int'(uop_load), int'(uop_store), int'(uop_reg), int'(uop_offset)));
      if (stall_fetch) stall_cnt++;
      if (kill_decode) kill_cnt++;
      if (uop_last) last_cnt++;
    end

    // Advance the model with the inputs the coming rising edge will sample.
    if (reset) begin
      m_on = 1; m_busy = 0; m_q.delete();
    end else if (flush) begin
      m_busy = 0; m_q.delete();
    end else if (!m_busy) begin
      if (lmsm && lst != 0 && !hold) begin
        m_q.delete();
        for (int i = 0; i < 8; i++) if (lst[i]) m_q.push_back(i);
        m_base = int'(ir_in[11:9]);
        m_load = (ir_in[15:12] == 4'd6);
        m_off  = 0;
        m_busy = 1;
      end
    end else if (!hold) begin
      if (m_q.size() > 0) begin
        void'(m_q.pop_front());
        m_off++;
`ifndef LMSM_BASE_WB_EN
        if (m_q.size() == 0) m_busy = 0;
`endif
      end else begin
        m_busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_q.delete();
    stall_cnt = 0; kill_cnt = 0; last_cnt = 0;
  endtask

  task automatic check_log(input string name, input int exp[$]);
    chk($sformatf("%s_count", name), log_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_uop%0d", name, i), (i < log_q.size()) ? log_q[i] : -1, exp[i]);
  endtask

  // Present an instruction and hold it until the sequencer releases fetch.
  task automatic issue(input logic [15:0] ir, input logic [15:0] nxt, input bit nxt_v,
                       input string name);
    bit done = 0;
    ir_in = ir; ir_valid = 1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = !stall_fetch;
      tick();
    end
    if (!done) chk({name, "_release_timeout"}, 0, 1);
    ir_in = nxt; ir_valid = nxt_v;
  endtask

  int exp_q[$];

  initial begin
    reset = 1; ir_valid = 0; ir_in = '0; hold = 0; flush = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset_outputs", int'(dut_vec), 0);
    tick();

    // LM R2, {R0,R2,R5,R7}
    clear_logs();
    issue(16'h64A5, 16'h0000, 0, "lm_a5");
    tick();
    exp_q = '{enc(1,0,0,0), enc(1,0,2,1), enc(1,0,5,2), enc(1,0,7,3)};
    check_log("lm_a5", exp_q);
    chk("lm_a5_stall_cycles", stall_cnt, 4);
    chk("lm_a5_last_cycles", last_cnt, 1);

    // SM with empty list
    clear_logs();
    issue(16'h7000, 16'h0000, 0, "sm_00");
    tick();
    chk("sm_00_uops", log_q.size(), 0);
    chk("sm_00_stall_cycles", stall_cnt, 0);
    chk("sm_00_kill_cycles", kill_cnt, 1);

    // SM with only R7
    clear_logs();
    issue(16'h7080, 16'h0000, 0, "sm_80");
    tick();
    exp_q = '{enc(0,1,7,0)};
    check_log("sm_80", exp_q);
    chk("sm_80_stall_cycles", stall_cnt, 1);
    chk("sm_80_last_cycles", last_cnt, 1);

    // LM list 0x0F with hold over the second micro-op
    clear_logs();
    ir_in = 16'h600F; ir_valid = 1;
    tick();
    tick();
    hold = 1;
    repeat (3) tick();
    hold = 0;
    repeat (3) tick();
    ir_valid = 0;
    tick();
    exp_q = '{enc(1,0,0,0), enc(1,0,1,1), enc(1,0,2,2), enc(1,0,3,3)};
    check_log("lm_hold", exp_q);
    chk("lm_hold_stall_cycles", stall_cnt, 7);
    chk("lm_hold_last_cycles", last_cnt, 1);

    // LM list 0xFF flushed on the third micro-op
    clear_logs();
    ir_in = 16'h60FF; ir_valid = 1;
    repeat (3) tick();
    flush = 1;
    tick();
    flush = 0; ir_valid = 0;
    @(negedge clk);
    chk("flush_uop_valid", int'(uop_valid), 0);
    chk("flush_busy", int'(busy), 0);
    chk("flush_stall", int'(stall_fetch), 0);
    tick();
    exp_q = '{enc(1,0,0,0), enc(1,0,1,1)};
    check_log("flush", exp_q);
    chk("flush_stall_cycles", stall_cnt, 4);

    // Reset in the middle of a sequence
    ir_in = 16'h60FF; ir_valid = 1;
    repeat (2) tick();
    reset = 1; ir_valid = 0;
    tick();
    reset = 0;
    @(negedge clk);
    chk("midseq_reset_outputs", int'(dut_vec), 0);
    tick();

    // Back-to-back LM {R0,R1} then SM R2, {R2,R3}
    clear_logs();
    issue(16'h6003, 16'h740C, 1, "b2b_lm");
    issue(16'h740C, 16'h0000, 0, "b2b_sm");
    tick();
    exp_q = '{enc(1,0,0,0), enc(1,0,1,1), enc(0,1,2,0), enc(0,1,3,1)};
    check_log("b2b", exp_q);
    chk("b2b_stall_cycles", stall_cnt, 4);
    chk("b2b_last_cycles", last_cnt, 2);

    // LM R3, {R0,R2}
    clear_logs();
    issue(16'h6605, 16'h0000, 0, "lm_05");
    tick();
`ifdef LMSM_BASE_WB_EN
    exp_q = '{enc(1,0,0,0), enc(1,0,2,1), enc(0,0,3,2)};
    check_log("lm_05_wb", exp_q);
    chk("lm_05_wb_stall_cycles", stall_cnt, 3);
`else
    exp_q = '{enc(1,0,0,0), enc(1,0,2,1)};
    check_log("lm_05", exp_q);
    chk("lm_05_stall_cycles", stall_cnt, 2);
`endif
    chk("lm_05_last_cycles", last_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lmsm_sequencer.md
Name: lmsm_sequencer

Overview:
- Multi-cycle micro-op sequencer for the LM/SM (load/store multiple) instructions in the 5-stage pipeline.
- Sits beside the ID/RR stage. It detects LM/SM in the IF/ID instruction register, freezes fetch and IF/ID, and kills the normal decode.
- It then emits one single-register load/store micro-op per cycle into the ID/EX input mux, walking the 8-bit register list.
- Sequencing stops when the list is exhausted, on flush, or on reset.

Parameters:
- XLEN, 16, datapath and offset width.
- LIST_W, 8, register-list width; bit i of ir[7:0] selects Ri.
- RA_W, 3, register address width.
- OPC_LM, 4'b0110, LM opcode (ir[15:12]).
- OPC_SM, 4'b0111, SM opcode (ir[15:12]).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ir_valid  in  1  IF/ID holds a valid instruction
- ir_in  in  16  IF/ID instruction register
- hold  in  1  downstream stall (ID/EX not advancing); freezes the sequencer
- flush  in  1  control-flow redirect from EX; aborts the sequence
- stall_fetch  out  1  deassert PC enable and IF/ID enable
- kill_decode  out  1  zero the decoder's control bundle into ID/EX
- busy  out  1  sequencer in SEQ state
- uop_valid  out  1  micro-op present this cycle
- uop_load  out  1  micro-op is a load (LM)
- uop_store  out  1  micro-op is a store (SM)
- uop_reg  out  3  register written (LM) or read (SM)
- uop_base  out  3  base register RA (ir[11:9])
- uop_offset  out  16  address offset; memory address = R[uop_base] + uop_offset
- uop_last  out  1  final micro-op of the sequence

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. Reset has priority over everything, including mid-sequence.
- Reset values: state=IDLE, mask=0, count=0. All outputs 0.
- States: IDLE, SEQ. The WB state is added only by the optional feature.
- start = IDLE & ir_valid & ir_in[15:12]∈{OPC_LM,OPC_SM} & ir_in[7:0]!=0 & !flush.
- IDLE, start=1:
  - Combinationally assert stall_fetch=1 and kill_decode=1.
  - If hold=0: latch mask=ir_in[7:0], base=ir_in[11:9], is_load=(opcode==OPC_LM), count=0; next state SEQ.
  - If hold=1: stay in IDLE; stall_fetch and kill_decode remain asserted.
- IDLE, LM/SM with empty list: no micro-op and no stall. kill_decode=1 for that one cycle, so the instruction retires as a NOP.
- SEQ outputs (combinational from registers):
  - uop_valid=1; uop_load=is_load; uop_store=!is_load.
  - uop_reg = index of the lowest set bit of mask.
  - uop_offset = zero-extended count.
  - uop_base = latched base.
  - uop_last = (mask has exactly one bit set).
- SEQ advance, when hold=0: clear the lowest set bit, count+=1. If uop_last, next state IDLE.
- SEQ stall and kill: stall_fetch = kill_decode = !(uop_last & !hold), i.e. fetch is released in the cycle the last micro-op issues.
- SEQ with hold=1: mask, count and state frozen; outputs stable.
- Stall length: IF/ID is held for exactly N cycles for N list bits when hold=0 throughout.
- Order: ascending register index, R0 first. Offsets are consecutive, 0..N-1, independent of which bits are set.
- flush=1, any state: next state IDLE, mask=0. It has priority over hold and start.
  - Outputs in the flush cycle still reflect the current state; the pipeline squashes them.
  - uop_valid=0 from the next cycle.
- The sequencer does not re-check ir_in while in SEQ; the LM/SM stays parked in IF/ID until release.
- busy = (state != IDLE).

Optional Feature:
- Macro: LMSM_BASE_WB_EN.
- Defined:
  - After the last transfer, one extra micro-op in state WB: uop_valid=1, uop_load=0, uop_store=0, uop_reg=base, uop_offset=N.
  - The pipeline computes RA←RA+N from this micro-op.
  - uop_last moves to the WB cycle; stall length becomes N+1.
  - hold and flush apply identically in WB.
- Not defined: WB state absent; behaviour exactly as above.

Decomposition:
- Package lmsm_pkg:
  - Opcode constants OPC_LM and OPC_SM.
  - State enum {IDLE, SEQ, WB}.
  - Widths XLEN, LIST_W, RA_W.
- Sub-module lsb_priority_encoder (LIST_W → index + onehot + exactly_one flag). It is combinational and is instantiated once on mask.

Test Plan:
- LM, ir_in=16'h64A5 (RA=R2, list=0xA5), hold=0 -> micro-ops (reg,offset) = (0,0),(2,1),(5,2),(7,3); uop_last only on the 4th; stall_fetch high 4 cycles; all uop_base=2; uop_load=1.
- SM, list=0x00 -> no uop_valid, stall_fetch never asserted, kill_decode high 1 cycle; SM, list=0x80 -> one micro-op reg=7, offset=0, uop_last=1, uop_store=1, stall_fetch high 1 cycle.
- LM, list=0x0F, hold=1 during 2nd micro-op for 3 cycles -> reg=1/offset=1 stable for 4 cycles, then (2,2),(3,3); stall_fetch high 7 cycles total.
- LM, list=0xFF, flush on 3rd micro-op -> uop_valid=0 next cycle, busy=0, stall_fetch=0; reset asserted mid-sequence on another run -> all outputs 0 next cycle.
- Back-to-back: LM list=0x03 followed by SM list=0x0C in IF/ID -> (0,0),(1,1) then start cycle, then (2,0),(3,1) store; no micro-op lost or duplicated.
- With LMSM_BASE_WB_EN, LM list=0x05 RA=R3 -> (0,0),(2,1), then WB micro-op reg=3, offset=2, uop_last=1; stall_fetch high 3 cycles.
